// File: rtl/a2d_scan_ctrl_pkg.sv
// Shared types and command-frame layout for the A2D scan controller.
package a2d_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CH_MSB     = 13;
    localparam int unsigned CH_LSB     = 11;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        SCAN,
        FLUSH,
        DONE
    } scan_state_e;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_LEAD,
        SPI_LOW,
        SPI_HIGH,
        SPI_TRAIL
    } spi_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } ch_sel_t;

    // Lowest set mask bit at index >= lo; downward scan so the lowest hit wins.
    function automatic ch_sel_t find_from(input logic [7:0] mask, input logic [3:0] lo);
        ch_sel_t r;
        r = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (mask[i-1] && ((i - 1) >= 32'(lo))) begin
                r.found = 1'b1;
                r.idx   = 3'(i - 1);
            end
        end
        return r;
    endfunction

    function automatic logic [FRAME_BITS-1:0] make_cmd(input logic [2:0] ch);
        logic [FRAME_BITS-1:0] c;
        c = '0;
        c[CH_MSB:CH_LSB] = ch;
        return c;
    endfunction

endpackage

// File: rtl/a2d_scan_ctrl_if.sv
// Host control/result and ADC serial signals of the scan controller.
interface a2d_scan_ctrl_if;
    logic        start;
    logic        cont;
    logic [7:0]  ch_mask;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        busy;
    logic        res_vld;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic        sweep_done;

    modport master (
        input  start, cont, ch_mask, MISO,
        output SS_n, SCLK, MOSI, busy, res_vld, res_ch, res_data, sweep_done
    );

    modport slave (
        output start, cont, ch_mask, MISO,
        input  SS_n, SCLK, MOSI, busy, res_vld, res_ch, res_data, sweep_done
    );
endinterface

// File: rtl/a2d_scan_ctrl_spi_mstr16.sv
// 16-bit SPI master, SCLK idles high, MOSI driven on fall, MISO sampled on rise.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] tx,
    output logic        done,
    output logic [15:0] rx,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);
    localparam int unsigned HALF = SCLK_DIV / 2;

    spi_state_e  st, st_nx;
    logic [15:0] cnt;
    logic [15:0] sh;
    logic [4:0]  bits;
    logic        half_end;

    assign half_end = (cnt == 16'(HALF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= SPI_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            SPI_IDLE:           if (wrt)      st_nx = SPI_LEAD;
            SPI_LEAD, SPI_HIGH: if (half_end) st_nx = SPI_LOW;
            SPI_LOW:            if (half_end) st_nx = (bits == 5'd15) ? SPI_TRAIL : SPI_HIGH;
            SPI_TRAIL:          if (half_end) st_nx = SPI_IDLE;
            default:            st_nx = SPI_IDLE;
        endcase
    end

    // Pin outputs register the decode of the next state so they move with st.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sh   <= '0;
            bits <= '0;
            rx   <= '0;
            done <= 1'b0;
            SS_n <= 1'b1;
            SCLK <= 1'b1;
            MOSI <= 1'b0;
        end else begin
            cnt  <= (st_nx != st || st == SPI_IDLE) ? '0 : cnt + 16'd1;
            SS_n <= (st_nx == SPI_IDLE);
            SCLK <= (st_nx != SPI_LOW);
            done <= (st == SPI_TRAIL) && (st_nx == SPI_IDLE);
            if (st == SPI_IDLE && wrt) begin
                sh   <= tx;
                bits <= '0;
            end
            if (st_nx == SPI_LOW && st != SPI_LOW) begin
                MOSI <= sh[15];
                sh   <= {sh[14:0], 1'b0};
            end
            if (st == SPI_LOW && st_nx != SPI_LOW) begin
                rx   <= {rx[14:0], MISO};
                bits <= bits + 5'd1;
            end
            if (st_nx == SPI_IDLE) MOSI <= 1'b0;
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Sweep scheduler: walks the captured channel mask through a pipelined ADC.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32,
    parameter int unsigned GAP      = 4
) (
    input logic            clk,
    input logic            rst,
    a2d_scan_ctrl_if.master bus
);
    scan_state_e state, state_nx;
    logic [7:0]  mask_q;
    logic [2:0]  cur_ch, prev_ch;
    logic        in_flight;
    logic [15:0] gap_cnt;
    logic        wrt, done, busy, frame_state;
    logic [15:0] rx;
    logic        rx_hi_unused;
    logic        res_vld, sweep_done;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    ch_sel_t     nxt, first_cap, first_new;

    assign nxt          = find_from(mask_q, {1'b0, cur_ch} + 4'd1);
    assign first_cap    = find_from(mask_q, 4'd0);
    assign first_new    = find_from(bus.ch_mask, 4'd0);
    assign rx_hi_unused = ^rx[15:12];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (bus.start && bus.ch_mask != '0) state_nx = PRIME;
            PRIME, SCAN: if (done) state_nx = nxt.found ? SCAN : FLUSH;
            FLUSH:       if (done) state_nx = DONE;
            DONE:        state_nx = (bus.cont && bus.ch_mask != '0) ? PRIME : IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        frame_state = (state == PRIME) || (state == SCAN) || (state == FLUSH);
        wrt         = frame_state && !in_flight && (gap_cnt == '0);
    end

    // cur_ch is the channel commanded in the running frame, prev_ch the one it returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q     <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            in_flight  <= 1'b0;
            gap_cnt    <= '0;
            res_vld    <= 1'b0;
            res_ch     <= '0;
            res_data   <= '0;
            sweep_done <= 1'b0;
        end else begin
            res_vld    <= 1'b0;
            sweep_done <= (state == DONE);
            if (wrt) in_flight <= 1'b1;
            if (done) begin
                in_flight <= 1'b0;
                gap_cnt   <= 16'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
            if (done && (state == SCAN || state == FLUSH)) begin
                res_vld  <= 1'b1;
                res_ch   <= prev_ch;
                res_data <= rx[11:0];
            end
            if (done && (state == PRIME || state == SCAN)) begin
                prev_ch <= cur_ch;
                cur_ch  <= nxt.found ? nxt.idx : first_cap.idx;
            end
            if ((state == IDLE || state == DONE) && state_nx == PRIME) begin
                mask_q <= bus.ch_mask;
                cur_ch <= first_new.idx;
            end
        end
    end

    spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt),
        .tx   (make_cmd(cur_ch)),
        .done (done),
        .rx   (rx),
        .SS_n (bus.SS_n),
        .SCLK (bus.SCLK),
        .MOSI (bus.MOSI),
        .MISO (bus.MISO)
    );

    assign bus.busy       = busy;
    assign bus.res_vld    = res_vld;
    assign bus.res_ch     = res_ch;
    assign bus.res_data   = res_data;
    assign bus.sweep_done = sweep_done;

endmodule

// File: doc/a2d_scan_ctrl.md
A2D_SCAN_CTRL -- requirements
Module: a2d_scan_ctrl

Interface
REQ-001 Parameter SCLK_DIV, default 32: clk cycles per SCLK period; even, >=4.
REQ-002 Parameter GAP, default 4: clk cycles SS_n stays high between frames.
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle strobe; begins one scan sweep.
REQ-006 cont  in  1  continuous mode; when 1, a new sweep starts after each sweep_done.
REQ-007 ch_mask  in  8  channels to convert; bit i enables CH i.
REQ-008 SS_n  out  1  active-low ADC slave select.
REQ-009 SCLK  out  1  serial clock to ADC; idles high.
REQ-010 MOSI  out  1  serial command to ADC, MSB first.
REQ-011 MISO  in  1  serial data from ADC, MSB first.
REQ-012 busy  out  1  high from the accepted start until sweep_done.
REQ-013 res_vld  out  1  one-cycle strobe; res_ch/res_data valid.
REQ-014 res_ch  out  3  channel of the current result.
REQ-015 res_data  out  12  conversion result (rx frame bits [11:0]).
REQ-016 sweep_done  out  1  one-cycle strobe after the final result of a sweep.

Function
REQ-017 Frame: SS_n falls; SCLK stays high SCLK_DIV/2 cycles; then 16 SCLK periods; SS_n rises SCLK_DIV/2 cycles after the last rising edge.
REQ-018 MOSI changes on SCLK fall; MISO is sampled on SCLK rise; 16 bits each way.
REQ-019 Tx command = {2'b00, ch[2:0], 11'b0}; ch is the channel for the ADC's next conversion.
REQ-020 Rx data of frame k is the channel commanded in frame k-1 (one-frame pipeline).
REQ-021 On an accepted start the controller captures ch_mask; the sweep visits set bits in ascending index.
REQ-022 Sweep of N enabled channels = N+1 frames: frame 0 primes ch_0 and its rx is discarded; frame k (1..N-1) commands ch_k and returns ch_(k-1); frame N commands ch_0 and returns ch_(N-1).
REQ-023 res_vld pulses exactly 1 cycle after each non-prime frame's SS_n rise; N strobes per sweep.
REQ-024 sweep_done pulses in the cycle after the Nth res_vld; busy falls in that same cycle.
REQ-025 Between frames, SS_n stays high for GAP cycles minimum.
REQ-026 FSM states: IDLE, PRIME, SCAN, FLUSH, DONE. Transitions: IDLE->PRIME on start with mask!=0; PRIME->SCAN on frame end (N>1); PRIME->FLUSH on frame end (N==1); SCAN->FLUSH after frame commanding last channel; FLUSH->DONE on frame end; DONE->PRIME if cont and captured mask!=0, else IDLE.
REQ-027 start while busy is ignored; start with ch_mask==0 is ignored (no frame, no strobes).
REQ-028 A ch_mask change during a sweep has no effect until the next sweep capture; in cont mode, ch_mask is recaptured in DONE.
REQ-029 cont deasserted mid-sweep: the current sweep completes, then IDLE.
REQ-030 Single channel (mask 8'h10): 2 frames, both commanding CH4; 1 result with res_ch=4.

Reset
REQ-031 rst asynchronously forces state=IDLE, SS_n=1, SCLK=1, MOSI=0, busy=0, res_vld=0, sweep_done=0, res_ch=0, res_data=0, captured mask=0.
REQ-032 rst mid-frame aborts the frame immediately; no res_vld results from the partial frame.

Structure
REQ-033 Shared package a2d_pkg holds the state enum, the cmd field positions (CH_MSB=13, CH_LSB=11) and FRAME_BITS=16.
REQ-034 Sub-module spi_mstr16 (clk, rst, wrt, tx[15:0], done, rx[15:0], SS_n, SCLK, MOSI, MISO) implements REQ-017/018; the scheduler issues wrt and consumes done.
REQ-035 Next-channel select is a priority search over the captured mask above the current index.

Verification
REQ-036 Mask 8'hFF, start, ADC model CHi=12'h100*i+i -> 9 frames, results CH0..CH7 = 12'h000, 12'h101, ... 12'h707 in order, then sweep_done.
REQ-037 Mask 8'b1010_0100 -> 4 frames, commands CH2, CH5, CH7, CH2; results ch 2, 5, 7; busy high throughout.
REQ-038 Mask 8'h00 plus start -> SS_n stays 1, busy stays 0, no strobes; start pulsed while busy -> sweep unchanged.
REQ-039 cont=1, mask 8'h03 -> repeated 3-frame sweeps with GAP >= 4 between frames; cont dropped mid-sweep -> exactly one more sweep_done, then IDLE.
REQ-040 rst asserted at SCLK edge 7 of frame 2 -> SS_n=1 and SCLK=1 asynchronously, no res_vld; a new start afterwards runs a clean sweep from PRIME.
REQ-041 SCLK_DIV=4 and SCLK_DIV=32 -> SCLK period measured as 4 and 32 clk cycles; each frame has exactly 16 rising edges.
